// File: rtl/mem_seq_pkg.sv
// Shared definitions for the nibble-RAM word sequencer: state encoding and
// RAM geometry.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W   = 4;
  localparam int RAM_ADDR_W = 12;

endpackage

// File: rtl/mem_seq.sv
// Word-to-nibble sequencer: turns one CPU word access into NIBBLES consecutive
// little-endian RAM accesses. Optional alignment check: MEM_SEQ_ALIGN_CHECK_EN.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int ADDR_W  = RAM_ADDR_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [NIBBLE_W*NIBBLES-1:0]  wdata_i,
  output logic                         ready_o,
  output logic                         done_o,
  output logic [NIBBLE_W*NIBBLES-1:0]  rdata_o,
  output logic                         err_o,
  output logic                         ram_ren_o,
  output logic                         ram_wen_o,
  output logic [ADDR_W-1:0]            ram_addr_o,
  output logic [NIBBLE_W-1:0]          ram_din_o,
  input  logic [NIBBLE_W-1:0]          ram_dout_i
);

  localparam int WORD_W = NIBBLE_W * NIBBLES;
  localparam int CNT_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
  logic                err_q, err_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    err_d    = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          base_d  = addr_i;
          we_d    = we_i;
          wdata_d = wdata_i;
          cnt_d   = '0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
          if ((addr_i % ADDR_W'(NIBBLES)) != '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = XFER;
          end
`else
          state_d = XFER;
`endif
        end
      end

      XFER: begin
        if (!we_q) begin
          shadow_d[cnt_q*NIBBLE_W +: NIBBLE_W] = ram_dout_i;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
          // Publish the merged word on entry to DONE so rdata_o is valid with done_o.
          if (!we_q) begin
            rdata_d = shadow_d;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o    = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign rdata_o    = rdata_q;
  assign ram_ren_o  = (state_q == XFER) && !we_q;
  assign ram_wen_o  = (state_q == XFER) && we_q;
  assign ram_addr_o = (state_q == XFER) ? (base_q + ADDR_W'(cnt_q)) : '0;
  assign ram_din_o  = ram_wen_o ? wdata_q[cnt_q*NIBBLE_W +: NIBBLE_W] : '0;

`ifdef MEM_SEQ_ALIGN_CHECK_EN
  assign err_o = (state_q == DONE) && err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: drives it against a behavioural 4096x4 RAM and checks
// every completed word through a scoreboard fed by a word-level reference model.
module tb_mem_seq;
  import mem_seq_pkg::*;

  localparam int NIBBLES = 4;
  localparam int WORD_W  = 4 * NIBBLES;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 4096;

  logic              clk = 1'b0;
  logic              rstI;
  logic              reqI;
  logic              weI;
  logic [ADDR_W-1:0] addrI;
  logic [WORD_W-1:0] wdataI;
  logic              readyO;
  logic              doneO;
  logic [WORD_W-1:0] rdataO;
  logic              errO;
  logic              ramRen;
  logic              ramWen;
  logic [ADDR_W-1:0] ramAddr;
  logic [3:0]        ramDin;
  logic [3:0]        ramDout;
  logic              ramClear;

  always #5 clk = ~clk;

  mem_seq #(.NIBBLES(NIBBLES), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rstI), .req_i(reqI), .we_i(weI), .addr_i(addrI),
    .wdata_i(wdataI), .ready_o(readyO), .done_o(doneO), .rdata_o(rdataO),
    .err_o(errO), .ram_ren_o(ramRen), .ram_wen_o(ramWen), .ram_addr_o(ramAddr),
    .ram_din_o(ramDin), .ram_dout_i(ramDout)
  );

  // RAM block: synchronous write, combinational read.
  logic [3:0] ramArray [DEPTH];
  assign ramDout = ramRen ? ramArray[ramAddr] : 4'h0;
  always @(posedge clk) begin
    if (ramClear) begin
      for (int i = 0; i < DEPTH; i++) ramArray[i] <= 4'h0;
    end else if (ramWen) begin
      ramArray[ramAddr] <= ramDin;
    end
  end

  int cycleCnt;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int nChecks;
  int nPass;
  int strobeViol;
  int doneGap;
  int lastDone;
  logic renSeen;

  typedef struct {
    logic [WORD_W-1:0] rdata;
    logic              err;
    int                doneCycle;
  } exp_t;
  exp_t expQ[$];

  // Word-level reference: contents of RAM and the last word a read returned.
  logic [3:0]        refMem [DEPTH];
  logic [WORD_W-1:0] holdRdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t modelOp(input logic we, input logic [ADDR_W-1:0] addr,
                                   input logic [WORD_W-1:0] wdata, input int cyc);
    exp_t e;
    logic misaligned;
    logic [WORD_W-1:0] word;
    misaligned = 1'b0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    misaligned = (int'(addr) % NIBBLES) != 0;
`endif
    word = '0;
    e.err = misaligned;
    e.doneCycle = cyc + (misaligned ? 1 : NIBBLES + 1);
    if (!misaligned) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (we) refMem[(int'(addr) + k) % DEPTH] = wdata[4*k +: 4];
        else    word[4*k +: 4] = refMem[(int'(addr) + k) % DEPTH];
      end
      if (!we) holdRdata = word;
    end
    e.rdata = holdRdata;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse and tracks strobe rules every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rstI) begin
      if (ramRen && ramWen) strobeViol++;
      if ((ramRen || ramWen) && readyO) strobeViol++;
      if (errO && !doneO) strobeViol++;
      if (ramRen) renSeen = 1'b1;
    end
    if (doneO) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'(doneO), 32'h0);
      end else begin
        e = expQ.pop_front();
        checkOutput("doneCycle", cycleCnt, e.doneCycle);
        checkOutput("errFlag", 32'(errO), 32'(e.err));
        checkOutput("rdata", 32'(rdataO), 32'(e.rdata));
      end
      doneGap  = cycleCnt - lastDone;
      lastDone = cycleCnt;
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!readyO && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!readyO) checkOutput("readyTimeout", 32'(readyO), 32'h1);
  endtask

  // Called at a falling edge; returns one falling edge after acceptance.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [WORD_W-1:0] wdata);
    waitReady();
    reqI   = 1'b1;
    weI    = we;
    addrI  = addr;
    wdataI = wdata;
    expQ.push_back(modelOp(we, addr, wdata, cycleCnt));
    @(negedge clk);
    reqI   = 1'b0;
    weI    = 1'($urandom);
    addrI  = 12'($urandom);
    wdataI = 16'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || !readyO) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drainTimeout", 32'(expQ.size()), 32'h0);
  endtask

  task automatic checkRam(input string name, input int base, input logic [WORD_W-1:0] word);
    for (int k = 0; k < NIBBLES; k++)
      checkOutput(name, 32'(ramArray[(base + k) % DEPTH]), 32'(word[4*k +: 4]));
  endtask

  initial begin
    rstI = 1'b1; reqI = 1'b0; weI = 1'b0; addrI = '0; wdataI = '0;
    ramClear = 1'b1; holdRdata = '0; strobeViol = 0; lastDone = 0; doneGap = 0;
    renSeen = 1'b0; nChecks = 0; nPass = 0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 4'h0;
    repeat (3) @(negedge clk);
    ramClear = 1'b0;
    rstI = 1'b0;

    checkOutput("rstReady", 32'(readyO), 32'h1);
    checkOutput("rstDone", 32'(doneO), 32'h0);
    checkOutput("rstErr", 32'(errO), 32'h0);
    checkOutput("rstRdata", 32'(rdataO), 32'h0);
    checkOutput("rstRen", 32'(ramRen), 32'h0);
    checkOutput("rstWen", 32'(ramWen), 32'h0);
    checkOutput("rstAddr", 32'(ramAddr), 32'h0);
    checkOutput("rstDin", 32'(ramDin), 32'h0);

    // Write then read.
    applyStimulus(1'b1, 12'h010, 16'hBEEF);
    waitDrain();
    checkRam("ramBeef", 'h010, 16'hBEEF);
    applyStimulus(1'b0, 12'h010, 16'h0000);
    waitDrain();
    checkOutput("readBeef", 32'(rdataO), 32'hBEEF);

`ifndef MEM_SEQ_ALIGN_CHECK_EN
    // Address wrap from 0xFFF to 0x000.
    applyStimulus(1'b1, 12'hFFE, 16'h1234);
    waitDrain();
    checkRam("ramWrap", 'hFFE, 16'h1234);
    applyStimulus(1'b0, 12'hFFE, 16'h0000);
    waitDrain();
    checkOutput("readWrap", 32'(rdataO), 32'h1234);
`endif

    // Request during a busy transfer must be dropped.
    applyStimulus(1'b1, 12'h040, 16'h5A5A);
    reqI = 1'b1; weI = 1'b1; addrI = 12'h100; wdataI = 16'hFFFF;
    repeat (2) @(negedge clk);
    reqI = 1'b0;
    waitDrain();
    checkRam("ramBusyIgnored", 'h100, 16'h0000);
    checkRam("ramBusyWrite", 'h040, 16'h5A5A);

    // Reset during the second write cycle: two nibbles land, no done.
    waitReady();
    reqI = 1'b1; weI = 1'b1; addrI = 12'h020; wdataI = 16'hAAAA;
    @(negedge clk);
    reqI = 1'b0;
    @(negedge clk);
    rstI = 1'b1;
    @(negedge clk);
    checkOutput("midRstReady", 32'(readyO), 32'h1);
    checkOutput("midRstRen", 32'(ramRen), 32'h0);
    checkOutput("midRstWen", 32'(ramWen), 32'h0);
    checkOutput("midRstDone", 32'(doneO), 32'h0);
    rstI = 1'b0;
    refMem['h020] = 4'hA;
    refMem['h021] = 4'hA;
    holdRdata = '0;
    checkRam("ramMidRst", 'h020, 16'h00AA);
    applyStimulus(1'b0, 12'h020, 16'h0000);
    waitDrain();
    checkOutput("readMidRst", 32'(rdataO), 32'h00AA);

    // Back-to-back reads, second issued in the first IDLE cycle after done.
    applyStimulus(1'b1, 12'h014, 16'hC0DE);
    waitDrain();
    applyStimulus(1'b0, 12'h010, 16'h0000);
    applyStimulus(1'b0, 12'h014, 16'h0000);
    waitDrain();
    checkOutput("doneGap", doneGap, 6);
    checkOutput("readB2B", 32'(rdataO), 32'hC0DE);

`ifdef MEM_SEQ_ALIGN_CHECK_EN
    // Misaligned read completes immediately with err and no RAM activity.
    renSeen = 1'b0;
    applyStimulus(1'b0, 12'h011, 16'h0000);
    waitDrain();
    checkOutput("alignNoRen", 32'(renSeen), 32'h0);
    checkOutput("alignRdata", 32'(rdataO), 32'hC0DE);
`endif

    // Randomized traffic over a region away from the directed addresses.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 12'($urandom_range('h200, 'hEFF)), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitDrain();
    checkOutput("strobeRules", strobeViol, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Initiator-side sequencer for the 4096x4 nibble RAM.
- Accepts one 16-bit word read or write from the CPU datapath and performs NIBBLES consecutive nibble accesses on the RAM port, little-endian.
- Sits between CPU load/store logic and the RAM. It drives the RAM's ren/wen/addr/din and samples its combinational dout.

Parameters:
- NIBBLES, 4, nibbles per word; word width WORD_W = 4*NIBBLES.
- ADDR_W, 12, RAM nibble-address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  request strobe; sampled only when ready_o=1.
- we_i  in  1  1 = write, 0 = read; sampled with req_i.
- addr_i  in  ADDR_W  base nibble address of the word.
- wdata_i  in  WORD_W  write data; nibble k = wdata_i[4k+3:4k].
- ready_o  out  1  sequencer idle, can accept a request.
- done_o  out  1  one-cycle pulse when the transfer completes.
- rdata_o  out  WORD_W  read result; valid from done_o until the next accepted read.
- err_o  out  1  alignment error pulse (see Optional Feature).
- ram_ren_o  out  1  RAM read enable.
- ram_wen_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM nibble address.
- ram_din_o  out  4  RAM write nibble.
- ram_dout_i  in  4  RAM read nibble; combinational from ram_addr_o/ram_ren_o.

Behaviour:
- Reset values: state=IDLE, ready_o=1, done_o=0, err_o=0, rdata_o=0, ram_ren_o=0, ram_wen_o=0, ram_addr_o=0, ram_din_o=0, cnt=0.
- FSM states:
  - IDLE: ready_o=1, RAM strobes low. On req_i=1, latch addr_i, we_i, wdata_i; set cnt=0; go to XFER.
  - XFER: ready_o=0.
    - ram_addr_o = base+cnt, modulo 2^ADDR_W; wrap from 0xFFF to 0x000 is legal.
    - Write: ram_wen_o=1, ram_din_o = latched nibble cnt.
    - Read: ram_ren_o=1; ram_dout_i is captured into rdata shadow nibble cnt at the same rising edge.
    - cnt increments each cycle. When cnt==NIBBLES-1, go to DONE.
  - DONE: done_o=1 for exactly one cycle; RAM strobes low; rdata_o = shadow (reads only; writes leave rdata_o unchanged). Go to IDLE.
- RAM outputs are driven combinationally from the state/cnt/latched registers, so nibble k is presented during XFER cycle k.
- Latency: request accepted at edge E0; XFER occupies cycles E0+1..E0+NIBBLES; done_o is high in cycle E0+NIBBLES+1. For NIBBLES=4, done arrives 5 cycles after acceptance.
- Back-to-back: a new req_i is accepted in the IDLE cycle after DONE, so throughput is one word per NIBBLES+2 cycles.
- req_i while ready_o=0 is ignored and never queued. addr_i, we_i and wdata_i changes after acceptance have no effect.
- ram_ren_o and ram_wen_o are never high simultaneously. Both are low outside XFER.
- Reset mid-transfer: next edge returns to IDLE and strobes drop immediately. Nibbles already written stay in RAM (no rollback). done_o is not issued.

Optional Feature:
- Macro: MEM_SEQ_ALIGN_CHECK_EN.
- Defined:
  - A request with addr_i mod NIBBLES != 0 is accepted but skips XFER.
  - IDLE → DONE directly; done_o=1 and err_o=1 in the same cycle.
  - No RAM strobes are asserted; rdata_o is unchanged.
- Undefined:
  - Any address is legal and wraps as above.
  - err_o is tied to 0.

Decomposition:
- Shared package mem_seq_pkg holds:
  - state encoding constants IDLE=2'd0, XFER=2'd1, DONE=2'd2;
  - NIBBLE_W=4;
  - RAM_ADDR_W=12.
- No sub-module: FSM, counter and the nibble shift/mux stay flat in mem_seq.
- Bench instantiates mem_seq together with the existing ram block.

Test Plan:
- Write then read: write addr=0x010, wdata=0xBEEF → RAM[0x010..0x013]=F,E,E,B; done_o 5 cycles after acceptance. Read addr=0x010 → rdata_o=0xBEEF.
- Wrap-around (feature undefined): write addr=0xFFE, wdata=0x1234 → RAM[0xFFE]=4, RAM[0xFFF]=3, RAM[0x000]=2, RAM[0x001]=1. Readback gives 0x1234.
- Busy ignore: assert req_i with addr=0x100 during an active transfer → no second transfer, RAM[0x100..0x103] untouched, exactly one done_o pulse.
- Reset mid-write: write 0xAAAA to 0x020, assert rst_i in XFER cycle 2 → next cycle ready_o=1 and strobes low; RAM[0x020..0x021]=A, RAM[0x022..0x023]=0; no done_o.
- Back-to-back: reads at 0x010 and 0x014, the second req_i issued in the IDLE cycle right after done → two done pulses 6 cycles apart, rdata_o correct each time.
- MEM_SEQ_ALIGN_CHECK_EN defined: read addr=0x011 → done_o=1 and err_o=1 one cycle after acceptance, ram_ren_o never asserted, rdata_o unchanged.
